// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage with a single outstanding instruction-memory request, a
//   one-entry skid buffer for responses that arrive while the decoder stalls,
//   and branch redirection that drops any in-flight response.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   imem_req / imem_addr        request and word-aligned fetch address
//   imem_gnt                    memory accepted the request this cycle
//   imem_rvalid / imem_rdata    response strobe and instruction word
//   stall                       decoder does not consume inst this cycle
//   branch_taken/branch_target  redirect request from execute
//   inst_valid / inst / inst_pc instruction handed to the decoder
`timescale 1ns/1ps

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] START_PC = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] redirect_pc, redirect_pc_nxt;
  logic        drop, drop_nxt;
  logic        inst_valid_nxt;
  logic [31:0] inst_nxt, inst_pc_nxt;
  logic [31:0] skid_data, skid_data_nxt;
  logic [31:0] skid_pc, skid_pc_nxt;
  logic        out_free;
  logic [31:0] target;

  // pc addresses the request being made or awaited, so it stays stable on
  // imem_addr until the grant. When a redirect arrives with a request in
  // flight, the target is parked in redirect_pc until the stale response
  // has been swallowed.
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign target    = branch_target & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= START_PC;
      redirect_pc <= START_PC;
      drop        <= 1'b0;
      inst_valid  <= 1'b0;
      inst        <= NOP;
      inst_pc     <= 32'h0000_0000;
      skid_data   <= NOP;
      skid_pc     <= 32'h0000_0000;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      redirect_pc <= redirect_pc_nxt;
      drop        <= drop_nxt;
      inst_valid  <= inst_valid_nxt;
      inst        <= inst_nxt;
      inst_pc     <= inst_pc_nxt;
      skid_data   <= skid_data_nxt;
      skid_pc     <= skid_pc_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    redirect_pc_nxt = redirect_pc;
    drop_nxt        = drop;
    inst_valid_nxt  = inst_valid;
    inst_nxt        = inst;
    inst_pc_nxt     = inst_pc;
    skid_data_nxt   = skid_data;
    skid_pc_nxt     = skid_pc;
    out_free        = !inst_valid || !stall;

    // A consumed instruction leaves the output empty unless refilled below.
    if (!stall) begin
      inst_valid_nxt = 1'b0;
    end

    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_gnt) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (drop) begin
            drop_nxt  = 1'b0;
            pc_nxt    = redirect_pc;
            state_nxt = REQ;
          end else if (out_free) begin
            inst_valid_nxt = 1'b1;
            inst_nxt       = imem_rdata;
            inst_pc_nxt    = pc;
            pc_nxt         = pc + 32'd4;
            state_nxt      = REQ;
          end else begin
            skid_data_nxt = imem_rdata;
            skid_pc_nxt   = pc;
            pc_nxt        = pc + 32'd4;
            state_nxt     = HOLD;
          end
        end
      end
      HOLD: begin
        // Being in HOLD means the skid entry is occupied.
        if (!stall) begin
          inst_valid_nxt = 1'b1;
          inst_nxt       = skid_data;
          inst_pc_nxt    = skid_pc;
          state_nxt      = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Redirect overrides everything above, including stall.
    if (branch_taken) begin
      inst_valid_nxt = 1'b0;
      inst_nxt       = inst;
      inst_pc_nxt    = inst_pc;
      case (state)
        REQ: begin
          drop_nxt        = 1'b1;
          redirect_pc_nxt = target;
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop_nxt  = 1'b0;
            pc_nxt    = target;
            state_nxt = REQ;
          end else begin
            drop_nxt        = 1'b1;
            redirect_pc_nxt = target;
            pc_nxt          = pc;
            state_nxt       = WAIT;
          end
        end
        default: begin
          drop_nxt  = 1'b0;
          pc_nxt    = target;
          state_nxt = REQ;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 imem_req  output  1  SHALL request a fetch from instruction memory.
REQ-005 imem_addr  output  32  SHALL carry the fetch address, always word aligned.
REQ-006 imem_gnt  input  1  SHALL indicate that memory accepted the request this cycle.
REQ-007 imem_rvalid  input  1  SHALL indicate a valid imem_rdata, at least 1 cycle after the grant.
REQ-008 imem_rdata  input  32  SHALL carry the instruction word.
REQ-009 stall  input  1  SHALL mean the decoder/controller does not consume inst this cycle.
REQ-010 branch_taken  input  1  SHALL request a redirect (Branch AND ALU zero from execute).
REQ-011 branch_target  input  32  SHALL carry the redirect address.
REQ-012 inst_valid  output  1  SHALL mark inst/inst_pc as holding a valid instruction.
REQ-013 inst  output  32  SHALL carry the instruction word to the controller/decoder.
REQ-014 inst_pc  output  32  SHALL carry the address of inst.

Function
REQ-015 States SHALL be IDLE, REQ, WAIT and HOLD, with at most one memory request outstanding.
REQ-016 IDLE SHALL last one cycle after reset release, then go to REQ.
REQ-017 REQ SHALL drive imem_req=1 with imem_addr=pc, holding both stable until imem_gnt; on grant go to WAIT.
REQ-018 imem_req SHALL be 0 in IDLE, WAIT and HOLD.
REQ-019 In WAIT with imem_rvalid, if the output register is free (inst_valid=0 or stall=0), the block SHALL load inst=imem_rdata, inst_pc=pc, inst_valid=1, set pc=pc+4 and go to REQ.
REQ-020 In WAIT with imem_rvalid while inst_valid=1 and stall=1, the block SHALL store the word in a one-entry skid buffer, set pc=pc+4 and go to HOLD.
REQ-021 HOLD SHALL move the skid entry to the output registers on the first cycle with stall=0, then go to REQ.
REQ-022 While stall=1, inst, inst_pc and inst_valid SHALL remain unchanged.
REQ-023 With inst_valid=1 and stall=0 and no new word loaded, inst_valid SHALL clear on the next edge.
REQ-024 pc SHALL wrap modulo 2^32, so 32'hFFFF_FFFC+4 becomes 32'h0000_0000.
REQ-025 On branch_taken, the block SHALL set pc={branch_target[31:2],2'b00}, clear inst_valid and the skid buffer on the next edge, and take priority over stall.
REQ-026 On branch_taken in WAIT, or in REQ before the grant, the block SHALL set a drop flag, and the matching response SHALL be discarded without touching the outputs or pc.
REQ-027 In the cycle the dropped response arrives, the block SHALL clear the drop flag and go to REQ at the target.
REQ-028 When branch_taken and imem_rvalid occur in the same cycle, the response SHALL be discarded and the next request SHALL use the target.
REQ-029 Fetch-to-output latency SHALL be 1 cycle after imem_rvalid; the sustained rate with a 1-cycle memory SHALL be one instruction per 2 cycles.

Reset
REQ-030 While rst_n=0: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (nop), inst_pc=0, skid empty, drop flag 0.
REQ-031 Reset asserted mid-transaction SHALL abandon the outstanding request.
REQ-032 After reset, imem_rvalid SHALL be ignored until the first new grant.

Verification
REQ-033 Reset release, memory returns rvalid one cycle after gnt -> imem_addr=0, then 4, then 8; inst_pc 0, 4, 8 with inst_valid pulses every 2 cycles.
REQ-034 stall=1 for 5 cycles while a response arrives -> outputs frozen, state HOLD; stall=0 -> skid word output with the next inst_pc, no loss or duplication.
REQ-035 branch_taken with target 32'h0000_0103 while in WAIT -> response dropped, next imem_addr=32'h0000_0100, inst_valid=0 until the target word returns.
REQ-036 branch_taken in the same cycle as imem_rvalid and stall=1 -> data discarded, inst_valid=0 next cycle, next fetch at target.
REQ-037 RESET_PC=32'hFFFF_FFFC -> first inst_pc=32'hFFFF_FFFC, next imem_addr=32'h0000_0000.
REQ-038 rst_n pulsed low during WAIT -> outputs at reset values immediately; a stale rvalid after release is ignored and the fetch restarts at RESET_PC.
